// File: rtl/etapa_salida.sv
// etapa_salida -- output stage of the pipelined divider.
// Captures quotient/remainder/divide-by-zero results leaving the last pipeline
// stage into a small show-ahead FIFO and hands them to the consumer through a
// valid/ready handshake, so a slow consumer does not lose results until the
// FIFO is full.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   goIn          result valid from the last pipeline stage (push request)
//   quotientIn    quotient from the last stage
//   remainderIn   remainder from the last stage
//   divZeroIn     divisor was zero for this result
//   ready         consumer accepts the head entry this cycle
//   doneOut       head entry valid (FIFO not empty)
//   quotientOut   head quotient (0 when empty)
//   remainderOut  head remainder (0 when empty)
//   divZeroOut    head divide-by-zero flag (0 when empty)
//   count         entries currently stored
//   overflow      sticky: a result was dropped because the FIFO was full
//   clearOvf      synchronous clear of overflow (a same-cycle drop wins)
module etapa_salida #(
  parameter int AnchoQ      = 15,
  parameter int AnchoR      = 15,
  parameter int Profundidad = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           goIn,
  input  logic [AnchoQ:0]                quotientIn,
  input  logic [AnchoR:0]                remainderIn,
  input  logic                           divZeroIn,
  input  logic                           ready,
  output logic                           doneOut,
  output logic [AnchoQ:0]                quotientOut,
  output logic [AnchoR:0]                remainderOut,
  output logic                           divZeroOut,
  output logic [$clog2(Profundidad):0]   count,
  output logic                           overflow,
  input  logic                           clearOvf
);

  localparam int AnchoP    = $clog2(Profundidad);
  localparam int AnchoEnt  = AnchoQ + AnchoR + 3;
  localparam logic [AnchoP:0] CuentaLlena = (AnchoP + 1)'(Profundidad);
  localparam logic [AnchoP:0] CuentaCasi  = (AnchoP + 1)'(Profundidad - 1);

  typedef enum logic [1:0] {
    VACIO,
    PARCIAL,
    LLENO
  } ocupacionT;

  ocupacionT estado, estadoSig;

  logic [AnchoEnt-1:0] mem [Profundidad];
  logic [AnchoP-1:0]   wrPtr, rdPtr;
  logic [AnchoP:0]     countSig;
  logic                push, pop, drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = doneOut && ready;
  assign push = goIn && ((estado != LLENO) || pop);
  assign drop = goIn && (estado == LLENO) && !pop;

  always_comb begin
    estadoSig = estado;
    countSig  = count;
    unique case ({push, pop})
      2'b10:   countSig = count + (AnchoP + 1)'(1);
      2'b01:   countSig = count - (AnchoP + 1)'(1);
      default: countSig = count;
    endcase
    unique case (estado)
      VACIO:   if (push) estadoSig = PARCIAL;
      PARCIAL: begin
        if (push && !pop && count == CuentaCasi)
          estadoSig = LLENO;
        else if (pop && !push && count == (AnchoP + 1)'(1))
          estadoSig = VACIO;
      end
      LLENO:   if (pop && !push) estadoSig = PARCIAL;
      default: estadoSig = VACIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado   <= VACIO;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      estado <= estadoSig;
      count  <= countSig;
      if (push) wrPtr <= wrPtr + AnchoP'(1);
      if (pop)  rdPtr <= rdPtr + AnchoP'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clearOvf)
        overflow <= 1'b0;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= {quotientIn, remainderIn, divZeroIn};
  end

  // Show-ahead head; outputs depend only on registered state.
  always_comb begin
    doneOut      = (estado != VACIO);
    quotientOut  = '0;
    remainderOut = '0;
    divZeroOut   = 1'b0;
    if (doneOut) {quotientOut, remainderOut, divZeroOut} = mem[rdPtr];
  end

  // Unused-bit guard for CuentaLlena when the FIFO never reaches it elsewhere.
  logic unusedLlena;
  assign unusedLlena = (CuentaLlena == '0);

endmodule

// File: tb/tb_etapa_salida.sv
// tb_etapa_salida -- scoreboard bench for etapa_salida.
// Stimulus pushes the expected entry into a queue whenever a result should be
// accepted; a monitor at the falling edge pops and compares every time the
// DUT hands an entry to the consumer (doneOut && ready).
module tb_etapa_salida;

  logic        clk = 1'b0;
  logic        reset;
  logic        goIn;
  logic [15:0] quotientIn;
  logic [15:0] remainderIn;
  logic        divZeroIn;
  logic        ready;
  logic        doneOut;
  logic [15:0] quotientOut;
  logic [15:0] remainderOut;
  logic        divZeroOut;
  logic [2:0]  count;
  logic        overflow;
  logic        clearOvf;

  int passed = 0;
  int total  = 0;
  logic [32:0] sb[$];

  etapa_salida #(.AnchoQ(15), .AnchoR(15), .Profundidad(4)) dut (
    .clk(clk), .reset(reset), .goIn(goIn), .quotientIn(quotientIn),
    .remainderIn(remainderIn), .divZeroIn(divZeroIn), .ready(ready),
    .doneOut(doneOut), .quotientOut(quotientOut), .remainderOut(remainderOut),
    .divZeroOut(divZeroOut), .count(count), .overflow(overflow),
    .clearOvf(clearOvf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && doneOut && ready) begin
      logic [32:0] e;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got q=%0d r=%0d dz=%0d expected no entry",
                 quotientOut, remainderOut, divZeroOut);
      end else begin
        e = sb.pop_front();
        if ({quotientOut, remainderOut, divZeroOut} == e) passed++;
        else $display("FAIL sb_entry: got q=%0d r=%0d dz=%0d expected q=%0d r=%0d dz=%0d",
                      quotientOut, remainderOut, divZeroOut, e[32:17], e[16:1], e[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; acc says whether the entry must be accepted.
  task automatic drive(input logic g, input logic [15:0] q, input logic [15:0] r,
                       input logic dz, input logic rdy, input logic acc);
    goIn = g; quotientIn = q; remainderIn = r; divZeroIn = dz; ready = rdy;
    if (g && acc) sb.push_back({q, r, dz});
    step();
  endtask

  task automatic idle();
    goIn = 1'b0; quotientIn = '0; remainderIn = '0; divZeroIn = 1'b0; ready = 1'b0;
  endtask

  task automatic drainAll(input string name);
    int k;
    ready = 1'b1;
    k = 0;
    while (doneOut && k < 10) begin
      step();
      k++;
    end
    ready = 1'b0;
    chk({name, "_drained"}, int'(doneOut), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; clearOvf = 1'b0;
    idle();
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(doneOut), 0);
    chk("rst_ovf", int'(overflow), 0);
    #6 reset = 1'b1;
    step();

    // T2 single result 100/7
    drive(1'b1, 16'd14, 16'd2, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t2_done", int'(doneOut), 1);
    chk("t2_q", int'(quotientOut), 14);
    chk("t2_r", int'(remainderOut), 2);
    chk("t2_count", int'(count), 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t2_done_after", int'(doneOut), 0);
    chk("t2_count_after", int'(count), 0);

    // Empty + ready has no effect
    ready = 1'b1;
    step();
    chk("empty_ready_count", int'(count), 0);
    ready = 1'b0;

    // T3 ordering and pointer wrap
    for (int i = 0; i < 6; i++)
      drive(1'b1, 16'(i + 1), 16'd0, 1'b0, (i >= 2), 1'b1);
    idle();
    chk("t3_count", int'(count), 2);
    drainAll("t3");
    chk("t3_q_zero", int'(quotientOut), 0);

    // T4 full and drop
    for (int i = 0; i < 5; i++)
      drive(1'b1, 16'(10 + i), 16'd3, 1'b0, 1'b0, (i < 4));
    idle();
    chk("t4_count", int'(count), 4);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_head", int'(quotientOut), 10);
    step();
    chk("t4_stable", int'(quotientOut), 10);
    drainAll("t4");
    chk("t4_ovf_sticky", int'(overflow), 1);
    clearOvf = 1'b1;
    step();
    clearOvf = 1'b0;
    chk("t4_ovf_clear", int'(overflow), 0);

    // T5 full with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      drive(1'b1, 16'(20 + i), 16'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_full", int'(count), 4);
    drive(1'b1, 16'd24, 16'd0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("t5_head", int'(quotientOut), 21);
    chk("t5_count", int'(count), 4);
    chk("t5_ovf", int'(overflow), 0);
    // Drop and clear in the same cycle: set wins
    clearOvf = 1'b1;
    drive(1'b1, 16'd99, 16'd0, 1'b0, 1'b0, 1'b0);
    idle();
    clearOvf = 1'b0;
    chk("t5_setwins", int'(overflow), 1);
    chk("t5_head_kept", int'(quotientOut), 21);
    clearOvf = 1'b1;
    step();
    clearOvf = 1'b0;
    chk("t5_ovf_clear", int'(overflow), 0);
    drainAll("t5");

    // T6 divide-by-zero flag follows its entry
    drive(1'b1, 16'hFFFF, 16'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'd5, 16'd1, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t6_dz_head", int'(divZeroOut), 1);
    chk("t6_q_head", int'(quotientOut), 65535);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t6_dz_next", int'(divZeroOut), 0);
    chk("t6_q_next", int'(quotientOut), 5);
    drainAll("t6");

    // T1 asynchronous reset with three pending entries
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'(40 + i), 16'd7, 1'b1, 1'b0, 1'b1);
    idle();
    chk("t1_count_before", int'(count), 3);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    chk("t1_count", int'(count), 0);
    chk("t1_done", int'(doneOut), 0);
    chk("t1_q", int'(quotientOut), 0);
    chk("t1_r", int'(remainderOut), 0);
    chk("t1_dz", int'(divZeroOut), 0);
    chk("t1_ovf", int'(overflow), 0);
    #1 reset = 1'b1;
    step();
    chk("t1_after_count", int'(count), 0);

    chk("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
